instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory interface. It owns the fetch PC and issues word requests to the combinational instruction memory.
- Each returned word is captured with its PC into a small prefetch FIFO. Entries are delivered to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush plus new PC) and out-of-range or misaligned fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- FIFO_DEPTH, 4, prefetch entries; must be a power of two and ≥2.
- MEM_WORDS, 496, number of implemented memory words; any word index ≥ MEM_WORDS is a fault.
- NOP_INSTR, 32'h0000_0013, instruction returned on a fault entry (addi x0,x0,0).

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- instr_mem_req_o  out  1  memory access request.
- instr_mem_addr_o  out  32  byte address; always word-aligned when req is high.
- instr_mem_rd_data_i  in  32  memory data, valid in the same cycle as req (combinational responder).
- redirect_valid_i  in  1  one-cycle pulse: flush and refetch from redirect_pc_i.
- redirect_pc_i  in  32  target byte address.
- fetch_valid_o  out  1  FIFO head valid.
- fetch_ready_i  in  1  decode accepts head.
- fetch_instr_o  out  32  head instruction.
- fetch_pc_o  out  32  head PC.
- fetch_fault_o  out  1  head entry is a fault (instr = NOP_INSTR).

Behaviour:
- Reset (rst_i=1 at edge):
  - pc ← RESET_PC, FIFO emptied, state ← RUN.
  - Outputs while in reset: req_o=0, addr_o=RESET_PC, fetch_valid_o=0, fetch_instr_o=0, fetch_pc_o=0, fetch_fault_o=0.
  - Reset mid-operation discards all entries with no further handshakes.
  - rst_i overrides redirect.
- States:
  - RUN: fetching.
  - HALT: fault entry pushed, no requests.
  - RUN→HALT on pushing a fault entry.
  - HALT→RUN only on redirect with an aligned, in-range target, or on reset.
- pop = fetch_valid_o & fetch_ready_i.
- space = (count < FIFO_DEPTH) | pop.
- Request, combinational: instr_mem_req_o = RUN & ~redirect_valid_i & space & ~rst_i & pc_in_range & pc_aligned. instr_mem_addr_o = pc at all times.
- Push, RUN & ~redirect & space:
  - If in range and aligned: entry {pc, instr_mem_rd_data_i, 0}; pc ← pc+4, 32-bit wrap.
  - Otherwise: no request; entry {pc, NOP_INSTR, 1}; go to HALT; pc unchanged.
- Latency: a word requested at cycle N appears at the FIFO head with fetch_valid_o=1 at cycle N+1 if the FIFO was empty. Sustained throughput is 1 instruction/cycle while decode is ready.
- Full FIFO: a request is allowed only if a pop occurs in the same cycle (simultaneous push+pop keeps count). Without a pop, req_o=0 and pc holds.
- Empty FIFO: fetch_valid_o=0; fetch_instr_o/fetch_pc_o hold their last values, don't-care.
- Redirect, has priority over pop and push:
  - FIFO flushed at the edge and the pending pop is ignored.
  - pc ← redirect_pc_i; state ← RUN.
  - No request in the redirect cycle; the first request to the new target occurs the next cycle.
  - A misaligned target (bits[1:0]≠0) or out-of-range target produces a fault entry on that next cycle.
- Head outputs are registered directly from FIFO storage (read pointer). count width is $clog2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.
- Range: word index pc[31:2] < MEM_WORDS; otherwise fault.

Test Plan:
- Reset, memory words 0..3 = 11,22,33,44, ready=1 → req high from cycle 1. Heads (pc,instr) = (0,11),(4,22),(8,33),(C,44) on consecutive cycles, fault=0.
- ready=0 for 8 cycles after reset → exactly 4 requests (pc 0,4,8,C), then req=0 and pc holds at 0x10. Raising ready then yields 0,4,8,C,10 in order, with no gap at the full→pop transition.
- With 3 entries buffered, redirect to 0x40 during a pop → FIFO empty the next cycle, no pop counted, req with addr 0x40 the following cycle, first head pc=0x40.
- Redirect to 0x42 → one entry {pc=0x42, instr=0x13, fault=1}, then req stays 0. A later redirect to 0x0 resumes normal fetch.
- Sequential fetch reaching pc=0x7BC (word 495) then 0x7C0 → 0x7BC fetched normally. 0x7C0 gives a fault entry and HALT, with no request issued at 0x7C0.
- rst_i asserted with a full FIFO and ready=1 → next cycle valid=0, req=0, addr=RESET_PC, and no pop is observed.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues word requests to a combinational
// instruction memory and buffers returned words with their PCs in a prefetch FIFO.
`timescale 1ns/1ps

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MEM_WORDS  = 496,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_mem_req_o,
  output logic [31:0] instr_mem_addr_o,
  input  logic [31:0] instr_mem_rd_data_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic        fetch_fault_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] MEM_WORDS_C = 32'(MEM_WORDS);

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;

  logic [31:0] r_memPc    [FIFO_DEPTH];
  logic [31:0] r_memInstr [FIFO_DEPTH];
  logic        r_memFault [FIFO_DEPTH];

  logic [31:0] r_headPc;
  logic [31:0] r_headInstr;
  logic        r_headFault;

  logic             w_pcInRange;
  logic             w_pcAligned;
  logic             w_redirTargetOk;
  logic             w_valid;
  logic             w_pop;
  logic             w_space;
  logic             w_push;
  logic             w_pushFault;
  logic             w_req;
  logic [31:0]      w_pushInstr;
  logic [CNT_W-1:0] w_cntAfterPop;
  logic [PTR_W-1:0] w_rdNext;

  assign w_pcInRange     = ({2'b00, r_pc[31:2]} < MEM_WORDS_C);
  assign w_pcAligned     = (r_pc[1:0] == 2'b00);
  assign w_redirTargetOk = (redirect_pc_i[1:0] == 2'b00) &&
                           ({2'b00, redirect_pc_i[31:2]} < MEM_WORDS_C);

  // Valid is masked during reset so no handshake can complete in a reset cycle;
  // a redirect cancels any pop offered in the same cycle.
  assign w_valid       = (r_count != '0) && !rst_i;
  assign w_pop         = w_valid && fetch_ready_i && !redirect_valid_i;
  assign w_space       = (r_count < DEPTH_C) || w_pop;
  assign w_cntAfterPop = r_count - CNT_W'(w_pop);
  assign w_rdNext      = r_rdPtr + PTR_W'(w_pop);
  assign w_pushInstr   = w_pushFault ? NOP_INSTR : instr_mem_rd_data_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_push      = 1'b0;
    w_pushFault = 1'b0;
    w_req       = 1'b0;
    case (r_state)
      S_RUN: begin
        if (!redirect_valid_i && w_space) begin
          w_push = 1'b1;
          if (w_pcInRange && w_pcAligned) begin
            w_req = !rst_i;
          end else begin
            w_pushFault = 1'b1;
            w_nextState = S_HALT;
          end
        end
      end
      S_HALT: begin
        w_nextState = S_HALT;
      end
      default: begin
        w_nextState = S_RUN;
      end
    endcase
    // From HALT only a usable target restarts fetching; in RUN a bad target
    // is reported by a fault entry on the following cycle.
    if (redirect_valid_i) begin
      w_nextState = (r_state == S_RUN || w_redirTargetOk) ? S_RUN : S_HALT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc        <= RESET_PC;
      r_count     <= '0;
      r_rdPtr     <= '0;
      r_wrPtr     <= '0;
      r_headPc    <= '0;
      r_headInstr <= '0;
      r_headFault <= 1'b0;
    end else if (redirect_valid_i) begin
      r_pc    <= redirect_pc_i;
      r_count <= '0;
      r_rdPtr <= '0;
      r_wrPtr <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
        if (!w_pushFault) begin
          r_pc <= r_pc + 32'd4;
        end
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_rdPtr <= w_rdNext;
      // Head registers track the entry that sits at the read pointer after this edge.
      if (w_cntAfterPop != '0) begin
        r_headPc    <= r_memPc[w_rdNext];
        r_headInstr <= r_memInstr[w_rdNext];
        r_headFault <= r_memFault[w_rdNext];
      end else if (w_push) begin
        r_headPc    <= r_pc;
        r_headInstr <= w_pushInstr;
        r_headFault <= w_pushFault;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_memPc[r_wrPtr]    <= r_pc;
      r_memInstr[r_wrPtr] <= w_pushInstr;
      r_memFault[r_wrPtr] <= w_pushFault;
    end
  end

  assign instr_mem_req_o  = w_req;
  assign instr_mem_addr_o = r_pc;
  assign fetch_valid_o    = w_valid;
  assign fetch_instr_o    = r_headInstr;
  assign fetch_pc_o       = r_headPc;
  assign fetch_fault_o    = r_headFault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed sequences queue hand-computed entries,
// and a negedge monitor pops and compares them on every completed handshake.
`timescale 1ns/1ps

module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } entry_t;

  logic        clk;
  logic        rst_i;
  logic        instr_mem_req_o;
  logic [31:0] instr_mem_addr_o;
  logic [31:0] instr_mem_rd_data_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_fault_o;

  entry_t sbQueue[$];
  int     checks   = 0;
  int     failures = 0;
  int     reqCount = 0;

  instr_fetch_unit dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .instr_mem_req_o     (instr_mem_req_o),
    .instr_mem_addr_o    (instr_mem_addr_o),
    .instr_mem_rd_data_i (instr_mem_rd_data_i),
    .redirect_valid_i    (redirect_valid_i),
    .redirect_pc_i       (redirect_pc_i),
    .fetch_valid_o       (fetch_valid_o),
    .fetch_ready_i       (fetch_ready_i),
    .fetch_instr_o       (fetch_instr_o),
    .fetch_pc_o          (fetch_pc_o),
    .fetch_fault_o       (fetch_fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory: words 0..3 hold 11,22,33,44, the rest a tagged index.
  function automatic logic [31:0] memWord(input logic [29:0] idx);
    case (idx)
      30'd0:   memWord = 32'h0000_0011;
      30'd1:   memWord = 32'h0000_0022;
      30'd2:   memWord = 32'h0000_0033;
      30'd3:   memWord = 32'h0000_0044;
      default: memWord = 32'hC0DE_0000 | {2'b00, idx};
    endcase
  endfunction

  assign instr_mem_rd_data_i = memWord(instr_mem_addr_o[31:2]);

  // Monitor: counts requests and scores every completed handshake.
  always @(negedge clk) begin
    entry_t expEntry;
    if (instr_mem_req_o) begin
      reqCount++;
    end
    if (fetch_valid_o && fetch_ready_i && !redirect_valid_i) begin
      checks++;
      if (sbQueue.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_pop got pc=%h instr=%h fault=%0b required no handshake",
                 fetch_pc_o, fetch_instr_o, fetch_fault_o);
      end else begin
        expEntry = sbQueue.pop_front();
        if (fetch_pc_o !== expEntry.pc || fetch_instr_o !== expEntry.instr ||
            fetch_fault_o !== expEntry.fault) begin
          failures++;
          $display("[TB] FAIL head_entry got pc=%h instr=%h fault=%0b required pc=%h instr=%h fault=%0b",
                   fetch_pc_o, fetch_instr_o, fetch_fault_o,
                   expEntry.pc, expEntry.instr, expEntry.fault);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic rst, input logic redir, input logic [31:0] redirPc,
                               input logic ready);
    rst_i            = rst;
    redirect_valid_i = redir;
    redirect_pc_i    = redirPc;
    fetch_ready_i    = ready;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got %h required %h", name, actual, expected);
    end
  endtask

  task automatic expectEntry(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    entry_t e;
    e.pc    = pc;
    e.instr = instr;
    e.fault = fault;
    sbQueue.push_back(e);
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic endTest(input string name);
    checkOutput({name, "_queue_drained"}, 32'(sbQueue.size()), 32'd0);
    sbQueue.delete();
  endtask

  initial begin
    rst_i            = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'h0;
    fetch_ready_i    = 1'b0;
    @(posedge clk);
    #1;

    // Reset values and streaming of words 0..3 with decode always ready
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    tick();
    checkOutput("rst_req", instr_mem_req_o, 32'd0);
    checkOutput("rst_addr", instr_mem_addr_o, 32'h0);
    checkOutput("rst_valid", fetch_valid_o, 32'd0);
    checkOutput("rst_instr", fetch_instr_o, 32'h0);
    checkOutput("rst_pc", fetch_pc_o, 32'h0);
    checkOutput("rst_fault", fetch_fault_o, 32'd0);
    expectEntry(32'h0, 32'h11, 1'b0);
    expectEntry(32'h4, 32'h22, 1'b0);
    expectEntry(32'h8, 32'h33, 1'b0);
    expectEntry(32'hC, 32'h44, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t1_req_c1", instr_mem_req_o, 32'd1);
    checkOutput("t1_addr_c1", instr_mem_addr_o, 32'h0);
    tick();
    checkOutput("t1_latency_valid", fetch_valid_o, 32'd1);
    checkOutput("t1_latency_pc", fetch_pc_o, 32'h0);
    repeat (4) tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    endTest("t1");

    // Backpressure: fill to four entries, then drain without a bubble
    resetDut();
    reqCount = 0;
    expectEntry(32'h00, 32'h11, 1'b0);
    expectEntry(32'h04, 32'h22, 1'b0);
    expectEntry(32'h08, 32'h33, 1'b0);
    expectEntry(32'h0C, 32'h44, 1'b0);
    expectEntry(32'h10, 32'hC0DE_0004, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (8) tick();
    checkOutput("t2_req_count", 32'(reqCount), 32'd4);
    checkOutput("t2_full_req", instr_mem_req_o, 32'd0);
    checkOutput("t2_full_addr", instr_mem_addr_o, 32'h10);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t2_pop_req", instr_mem_req_o, 32'd1);
    checkOutput("t2_pop_addr", instr_mem_addr_o, 32'h10);
    repeat (5) tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    endTest("t2");

    // Redirect to 0x40 during a pop with three entries buffered
    resetDut();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) tick();
    expectEntry(32'h40, 32'hC0DE_0010, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1);
    checkOutput("t3_redir_req", instr_mem_req_o, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t3_flushed_valid", fetch_valid_o, 32'd0);
    checkOutput("t3_new_req", instr_mem_req_o, 32'd1);
    checkOutput("t3_new_addr", instr_mem_addr_o, 32'h40);
    tick();
    checkOutput("t3_head_valid", fetch_valid_o, 32'd1);
    checkOutput("t3_head_pc", fetch_pc_o, 32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    endTest("t3");

    // Misaligned redirect gives one fault entry and halts; redirect to 0 resumes
    resetDut();
    expectEntry(32'h42, 32'h13, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h42, 1'b0);
    checkOutput("t4_redir_req", instr_mem_req_o, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t4_fault_req", instr_mem_req_o, 32'd0);
    checkOutput("t4_fault_addr", instr_mem_addr_o, 32'h42);
    tick();
    checkOutput("t4_fault_valid", fetch_valid_o, 32'd1);
    checkOutput("t4_fault_flag", fetch_fault_o, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("t4_halt_valid", fetch_valid_o, 32'd0);
    checkOutput("t4_halt_req", instr_mem_req_o, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
    tick();
    expectEntry(32'h0, 32'h11, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t4_resume_req", instr_mem_req_o, 32'd1);
    checkOutput("t4_resume_addr", instr_mem_addr_o, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    endTest("t4");

    // Last implemented word 495 fetches normally; word 496 faults without a request
    resetDut();
    expectEntry(32'h7B8, 32'hC0DE_01EE, 1'b0);
    expectEntry(32'h7BC, 32'hC0DE_01EF, 1'b0);
    expectEntry(32'h7C0, 32'h13, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h7B8, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t5_req_7b8", instr_mem_req_o, 32'd1);
    checkOutput("t5_addr_7b8", instr_mem_addr_o, 32'h7B8);
    tick();
    checkOutput("t5_req_7bc", instr_mem_req_o, 32'd1);
    checkOutput("t5_addr_7bc", instr_mem_addr_o, 32'h7BC);
    tick();
    checkOutput("t5_req_7c0", instr_mem_req_o, 32'd0);
    checkOutput("t5_addr_7c0", instr_mem_addr_o, 32'h7C0);
    tick();
    tick();
    checkOutput("t5_halt_valid", fetch_valid_o, 32'd0);
    checkOutput("t5_halt_req", instr_mem_req_o, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    endTest("t5");

    // Reset with a full FIFO while decode is ready
    resetDut();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (4) tick();
    checkOutput("t6_full_valid", fetch_valid_o, 32'd1);
    checkOutput("t6_full_req", instr_mem_req_o, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("t6_rst_valid", fetch_valid_o, 32'd0);
    tick();
    checkOutput("t6_after_valid", fetch_valid_o, 32'd0);
    checkOutput("t6_after_req", instr_mem_req_o, 32'd0);
    checkOutput("t6_after_addr", instr_mem_addr_o, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    endTest("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
